// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter: RV32I load/store adapter to a byte-enabled, 1-cycle-latency word RAM.
// One request in flight; every output is driven from a register.
module lsu_mem_adapter #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_e;
    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  o;
    logic [1:0]  sz;
    logic        bad_f3, misaligned, out_of_range, req_err;
    logic [3:0]  be;
    logic [31:0] lane, shifted, ld;
    // Request decode: funct3[1:0] is the access size, funct3[2] the unsigned flag.
    always_comb begin
        o            = req_addr[1:0];
        sz           = req_funct3[1:0];
        be           = sz == 2'd0 ? 4'b0001 << o : sz == 2'd1 ? 4'b0011 << o : 4'b1111;
        lane         = sz == 2'd0 ? {4{req_wdata[7:0]}} : sz == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
        bad_f3       = req_we ? (req_funct3[2] || sz == 2'd3) : (sz == 2'd3 || req_funct3 == 3'b110);
        misaligned   = (sz == 2'd1 && o[0]) || (sz == 2'd2 && o != 2'd0);
        out_of_range = req_addr[31:2] >= 30'(MEM_WORDS);
        req_err      = bad_f3 || misaligned || out_of_range;
    end
    // Load extract: lane-shift so the addressed byte sits at bit 0, then extend.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        ld      = f3_q == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]}
                : f3_q == 3'b001 ? {{16{shifted[15]}}, shifted[15:0]}
                : f3_q == 3'b100 ? {24'h0, shifted[7:0]}
                : f3_q == 3'b101 ? {16'h0, shifted[15:0]}
                : shifted;
    end
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        mem_we_d    = 1'b0;
        mem_be_d    = 4'h0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d  = req_we;
                f3_d  = req_funct3;
                off_d = o;
                if (req_err) begin
                    state_d     = ERR;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d     = ISSUE;
                    mem_we_d    = req_we;
                    mem_be_d    = be;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_wdata_d = req_we ? lane : 32'h0;
                end
            end
            ISSUE: begin
                state_d     = we_q ? RESP : WAIT;
                rsp_valid_d = we_q;
            end
            WAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ld;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = state_d == IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule
